// File: rtl/log_normalizer.sv
// -----------------------------------------------------------------------------
// log_normalizer
//
// Sequential leading-one normalizer that feeds the iterative log2 fraction
// stage. An unsigned W-bit operand a is shifted left until its leading one
// reaches the MSB. The result is:
//   - a mantissa x in [1,2), as unsigned 1.N fixed point;
//   - the exponent e = floor(log2(a)).
// The block then satisfies log2(a) = e + log2(x).
//
// Handshake: the same start/done protocol as the downstream stage.
//   - done is high while the block is idle or armed.
//   - An operation is accepted on a start edge seen in ARMED.
//   - ARMED is only reached after start has been observed low.
//
// Parameters:
//   W  operand width (>= 2; >= 4 when the fast path is enabled)
//   N  mantissa fraction bits (N <= W-1)
//   E  exponent width (>= ceil(log2(W)))
//
// Ports:
//   clk    in   1      rising-edge clock
//   reset  in   1      synchronous, active-high reset
//   start  in   1      request; qualified by a preceding low level
//   a      in   W      operand, sampled on the accepting edge
//   x      out  [0:N]  mantissa; x[0] is the integer bit, x[1:N] the fraction
//   e      out  E      exponent (bit index of the leading one of a)
//   zero   out  1      last accepted operand was zero
//   done   out  1      high when not normalizing
//
// Build option:
//   LOG_NORM_FAST_EN  When defined, four leading zero bits are skipped in a
//                     single cycle whenever possible. Results are unchanged;
//                     only the latency is shorter.
// -----------------------------------------------------------------------------
module log_normalizer #(
  parameter int W = 32,
  parameter int N = 8,
  parameter int E = 5
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [W-1:0] a,
  output logic [0:N]   x,
  output logic [E-1:0] e,
  output logic         zero,
  output logic         done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    NORM  = 2'd2
  } state_t;

  state_t       state_reg, state_next;
  logic [W-1:0] s_reg,     s_next;
  logic [E-1:0] cnt_reg,   cnt_next;
  logic [0:N]   x_reg,     x_next;
  logic [E-1:0] e_reg,     e_next;
  logic         zero_reg,  zero_next;

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      s_reg     <= '0;
      cnt_reg   <= '0;
      x_reg     <= '0;
      e_reg     <= '0;
      zero_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      s_reg     <= s_next;
      cnt_reg   <= cnt_next;
      x_reg     <= x_next;
      e_reg     <= e_next;
      zero_reg  <= zero_next;
    end
  end

  // Next-state and datapath logic.
  always_comb begin
    state_next = state_reg;
    s_next     = s_reg;
    cnt_next   = cnt_reg;
    x_next     = x_reg;
    e_next     = e_reg;
    zero_next  = zero_reg;

    case (state_reg)
      IDLE: begin
        // A start still held from the previous request must drop first.
        // Otherwise one long pulse would launch a second operation.
        if (!start) begin
          state_next = ARMED;
        end
      end

      ARMED: begin
        if (start) begin
          s_next     = a;
          cnt_next   = E'(W - 1);
          state_next = NORM;
        end
      end

      NORM: begin
        if (s_reg == '0) begin
          // A zero operand has no leading one. Report it in a single cycle.
          zero_next  = 1'b1;
          x_next     = '0;
          e_next     = '0;
          state_next = IDLE;
        end else if (s_reg[W-1]) begin
          // The leading one is now at the MSB. The top N+1 bits form the
          // mantissa; the bits below it are truncated. cnt tracks the
          // original position of the bit that is now at the MSB.
          x_next     = s_reg[W-1 -: N+1];
          e_next     = cnt_reg;
          zero_next  = 1'b0;
          state_next = IDLE;
        end
`ifdef LOG_NORM_FAST_EN
        else if (s_reg[W-1 -: 4] == 4'b0000) begin
          // s is nonzero here, so cnt stays at or above 4. No wrap occurs.
          s_next   = s_reg << 4;
          cnt_next = cnt_reg - E'(4);
        end
`endif
        else begin
          s_next   = s_reg << 1;
          cnt_next = cnt_reg - E'(1);
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign x    = x_reg;
  assign e    = e_reg;
  assign zero = zero_reg;
  assign done = (state_reg != NORM);

endmodule

// File: tb/tb_log_normalizer.sv
// -----------------------------------------------------------------------------
// tb_log_normalizer
//
// Self-checking bench for log_normalizer with W=32, N=8, E=5.
//
// The reference model works from the mathematical definition of the result:
//   - e is the highest set bit of a;
//   - x = floor(a * 2^N / 2^e);
//   - the latency comes from the leading-one position.
//
// Directed cases come first, then randomized operands. The random operands
// are spread over every leading-one position.
// -----------------------------------------------------------------------------
module tb_log_normalizer;

  localparam int W = 32;
  localparam int N = 8;
  localparam int E = 5;

  logic         clk;
  logic         reset;
  logic         start;
  logic [W-1:0] a;
  logic [0:N]   x;
  logic [E-1:0] e;
  logic         zero;
  logic         done;

  int n_checks;
  int n_errors;

  log_normalizer #(.W(W), .N(N), .E(E)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .a     (a),
    .x     (x),
    .e     (e),
    .zero  (zero),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counts one comparison and reports it if the values differ.
  task automatic check_val(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model, derived from the arithmetic definition of the result.
  task automatic ref_model(input logic [W-1:0] av, output longint xr, output longint er,
                           output longint zr, output int lat);
    int p;
    p = -1;
    for (int i = 0; i < W; i++) begin
      if (av[i]) p = i;
    end
    if (p < 0) begin
      xr  = 0;
      er  = 0;
      zr  = 1;
      lat = 1;
    end else begin
      xr = (longint'(av) * (longint'(1) << N)) / (longint'(1) << p);
      er = p;
      zr = 0;
`ifdef LOG_NORM_FAST_EN
      lat = (W - 1 - p) / 4 + (W - 1 - p) % 4 + 1;
`else
      lat = W - p;
`endif
    end
  endtask

  // Drops start for one cycle so the DUT arms. It then raises start with
  // the operand, and returns just after the accepting edge.
  task automatic launch(input logic [W-1:0] av);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1;
    a     = av;
    @(posedge clk);
  endtask

  // Counts the done-low cycles, sampled on falling edges. Gives up after
  // the cycle budget.
  task automatic wait_done(output int lat);
    lat = 0;
    @(negedge clk);
    while (done == 1'b0 && lat < 100) begin
      lat++;
      @(negedge clk);
    end
  endtask

  task automatic run_op(input logic [W-1:0] av, input string tag);
    longint xr, er, zr;
    int     lat_exp, lat;
    ref_model(av, xr, er, zr, lat_exp);
    launch(av);
    wait_done(lat);
    check_val({tag, ".timeout"}, longint'(lat < 100), 1);
    check_val({tag, ".lat"},  lat, lat_exp);
    check_val({tag, ".x"},    longint'(x), xr);
    check_val({tag, ".e"},    longint'(e), er);
    check_val({tag, ".zero"}, longint'(zero), zr);
    $display("op %s a=0x%08h lat=%0d x=0x%03h e=%0d zero=%0b", tag, av, lat, x, e, zero);
  endtask

  initial begin
    longint xr, er, zr;
    int     lat_exp, lat;
    logic [W-1:0] rv;

    n_checks = 0;
    n_errors = 0;
    reset = 1'b1;
    start = 1'b0;
    a     = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_val("rst.done", longint'(done), 1);
    check_val("rst.x",    longint'(x), 0);
    check_val("rst.e",    longint'(e), 0);
    check_val("rst.zero", longint'(zero), 0);
    reset = 1'b0;

    // Directed cases. The expected values for the first four are also
    // spelled out as constants.
    run_op(32'h8000_0000, "msb");
    check_val("msb.xconst", longint'(x), 'h100);
    run_op(32'h0000_0001, "lsb");
    check_val("lsb.econst", longint'(e), 0);
    run_op(32'h0000_00B5, "b5");
    check_val("b5.xconst", longint'(x), 'h16A);
    run_op(32'h0000_0000, "zero");
    run_op(32'h0000_0003, "three");
    check_val("three.xconst", longint'(x), 'h180);

    // start stays high after completion. No new operation may begin and
    // the outputs must hold.
    repeat (4) begin
      @(negedge clk);
      check_val("hold.done", longint'(done), 1);
      check_val("hold.x",    longint'(x), 'h180);
      check_val("hold.e",    longint'(e), 1);
    end

    // Reset during the fifth normalizing cycle of a=1.
    launch(32'h0000_0001);
    repeat (5) @(negedge clk);
    check_val("mid.busy", longint'(done), 0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_val("mid.done", longint'(done), 1);
    check_val("mid.x",    longint'(x), 0);
    check_val("mid.e",    longint'(e), 0);
    check_val("mid.zero", longint'(zero), 0);
    $display("op reset_mid_op a=0x00000001 done=%0b x=0x%03h e=%0d", done, x, e);

    run_op(32'h0000_0010, "x10");
    check_val("x10.econst", longint'(e), 4);

    // Randomized operands across all leading-one positions.
    for (int i = 0; i < 40; i++) begin
      rv = $urandom;
      rv = rv >> $urandom_range(0, W - 1);
      if ($urandom_range(0, 15) == 0) rv = '0;
      run_op(rv, $sformatf("rnd%0d", i));
    end

    // Check the model-based latency against one final operation.
    ref_model(32'h0000_0001, xr, er, zr, lat_exp);
    launch(32'h0000_0001);
    wait_done(lat);
    check_val("final.lat", lat, lat_exp);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_errors);
    $finish;
  end

endmodule
